// File: rtl/fetch_stage_if.sv
// ============================================================================
// Module      : fetch_stage_if
// Description : Instruction-memory request/response bus between IF and imem.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : IF stage - PC, single-outstanding fetch engine, hold buffer,
//               and IF/ID pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        stall,
    input  wire logic        flush_IFID,
    input  wire logic        BranchTaken,
    input  wire logic [31:0] redirect_pc,
    fetch_stage_if.master    imem,
    output logic      [31:0] pc_ID,
    output logic      [31:0] instr_ID,
    output logic             valid_ID,
    output logic             fetch_wait
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_WAIT    = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;

    logic        req;
    logic [31:0] addr;
    logic        deliver;
    logic [31:0] deliver_pc;
    logic [31:0] deliver_instr;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_aligned;
    logic        unused_redirect_lsbs;

    assign pc_plus4             = pc_q + 32'd4;
    assign redirect_aligned     = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_pc_d     = hold_pc_q;
        hold_instr_d  = hold_instr_q;
        req           = 1'b0;
        addr          = pc_q;
        deliver       = 1'b0;
        deliver_pc    = pc_q;
        deliver_instr = imem.imem_rdata;

        case (state_q)
            S_FETCH: begin
                if (BranchTaken) begin
                    pc_d = redirect_aligned;
                end else begin
                    req     = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    if (BranchTaken) begin
                        pc_d    = redirect_aligned;
                        state_d = S_FETCH;
                    end else if (stall) begin
                        hold_pc_d    = pc_q;
                        hold_instr_d = imem.imem_rdata;
                        state_d      = S_HOLD;
                    end else begin
                        // Back-to-back: deliver and issue the next fetch together.
                        deliver = 1'b1;
                        pc_d    = pc_plus4;
                        req     = 1'b1;
                        addr    = pc_plus4;
                    end
                end else if (BranchTaken) begin
                    pc_d    = redirect_aligned;
                    state_d = S_DISCARD;
                end
            end
            S_HOLD: begin
                if (BranchTaken) begin
                    pc_d    = redirect_aligned;
                    state_d = S_FETCH;
                end else if (!stall) begin
                    deliver       = 1'b1;
                    deliver_pc    = hold_pc_q;
                    deliver_instr = hold_instr_q;
                    pc_d          = pc_plus4;
                    state_d       = S_FETCH;
                end
            end
            S_DISCARD: begin
                if (BranchTaken) begin
                    pc_d = redirect_aligned;
                end
                if (imem.imem_rvalid) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign imem.imem_req  = req & ~rst;
    assign imem.imem_addr = addr;
    assign fetch_wait     = ((state_q == S_WAIT) || (state_q == S_DISCARD)) && !imem.imem_rvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            hold_pc_q    <= 32'd0;
            hold_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_ID    <= 32'd0;
            instr_ID <= NOP_INSTR;
            valid_ID <= 1'b0;
        end else if (flush_IFID) begin
            instr_ID <= NOP_INSTR;
            valid_ID <= 1'b0;
        end else if (stall) begin
            pc_ID    <= pc_ID;
            instr_ID <= instr_ID;
            valid_ID <= valid_ID;
        end else if (deliver) begin
            pc_ID    <= deliver_pc;
            instr_ID <= deliver_instr;
            valid_ID <= 1'b1;
        end else begin
            instr_ID <= NOP_INSTR;
            valid_ID <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Scoreboarded bench for fetch_stage with a variable-latency imem.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fetch_stage;

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush_IFID;
    logic        BranchTaken;
    logic [31:0] redirect_pc;
    logic [31:0] pc_ID;
    logic [31:0] instr_ID;
    logic        valid_ID;
    logic        fetch_wait;

    always #5 clk = ~clk;

    fetch_stage_if imem ();

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (C_NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush_IFID  (flush_IFID),
        .BranchTaken (BranchTaken),
        .redirect_pc (redirect_pc),
        .imem        (imem),
        .pc_ID       (pc_ID),
        .instr_ID    (instr_ID),
        .valid_ID    (valid_ID),
        .fetch_wait  (fetch_wait)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pc_q[$];

    int          lat;
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          fw_count;
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_fw;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive memory response, sample comb outputs mid-cycle,
    // then sample IF/ID just after the edge and feed both scoreboards.
    task automatic run_cycle();
        logic [31:0] e;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = 32'hDEAD_BEEF;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                mem_busy         = 1'b0;
                imem.imem_rvalid = 1'b1;
                imem.imem_rdata  = instr_of(mem_addr);
            end
        end
        #1;
        s_req  = imem.imem_req;
        s_addr = imem.imem_addr;
        s_fw   = fetch_wait;
        if (fetch_wait) fw_count++;
        if (imem.imem_req) begin
            if (mem_busy) check_eq("req_while_busy", 32'(imem.imem_req), 32'd0);
            if (exp_addr_q.size() == 0) begin
                check_eq("req_unexpected", 32'(imem.imem_req), 32'd0);
            end else begin
                e = exp_addr_q.pop_front();
                check_eq("imem_addr", imem.imem_addr, e);
            end
            if (!rst) begin
                mem_busy = 1'b1;
                mem_cnt  = lat;
                mem_addr = imem.imem_addr;
            end
        end
        @(posedge clk);
        #1;
        if (valid_ID && !stall && !flush_IFID && !rst) begin
            if (exp_pc_q.size() == 0) begin
                check_eq("id_unexpected", 32'(valid_ID), 32'd0);
            end else begin
                e = exp_pc_q.pop_front();
                check_eq("pc_ID", pc_ID, e);
                check_eq("instr_ID", instr_ID, instr_of(e));
            end
        end
    endtask

    initial begin
        rst              = 1'b1;
        stall            = 1'b0;
        flush_IFID       = 1'b0;
        BranchTaken      = 1'b0;
        redirect_pc      = 32'd0;
        lat              = 1;
        mem_busy         = 1'b0;
        mem_cnt          = 0;
        mem_addr         = 32'd0;
        fw_count         = 0;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = 32'd0;
        @(posedge clk);
        #1;

        // Reset
        run_cycle();
        run_cycle();
        check_eq("rst_req", 32'(s_req), 32'd0);
        check_eq("rst_pc_ID", pc_ID, 32'd0);
        check_eq("rst_instr_ID", instr_ID, C_NOP);
        check_eq("rst_valid_ID", 32'(valid_ID), 32'd0);

        // Back-to-back fetch with 1-cycle memory
        rst = 1'b0;
        for (int i = 0; i < 5; i++) exp_addr_q.push_back(32'(4 * i));
        for (int i = 0; i < 4; i++) exp_pc_q.push_back(32'(4 * i));
        for (int i = 0; i < 5; i++) begin
            run_cycle();
            check_eq("b2b_req", 32'(s_req), 32'd1);
            check_eq("b2b_valid", 32'(valid_ID), (i == 0) ? 32'd0 : 32'd1);
        end

        // Stall for 4 cycles while the 0x10 response arrives
        exp_pc_q.push_back(32'h10);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            check_eq("hold_noreq", 32'(s_req), 32'd0);
            check_eq("stall_pc_ID", pc_ID, 32'hC);
            check_eq("stall_valid", 32'(valid_ID), 32'd1);
        end
        stall = 1'b0;
        run_cycle();
        check_eq("unhold_noreq", 32'(s_req), 32'd0);
        check_eq("unhold_pc_ID", pc_ID, 32'h10);

        // 3-cycle memory latency
        lat = 3;
        exp_addr_q.push_back(32'h14);
        exp_addr_q.push_back(32'h18);
        exp_addr_q.push_back(32'h1C);
        exp_pc_q.push_back(32'h14);
        exp_pc_q.push_back(32'h18);
        fw_count = 0;
        for (int k = 0; k < 7; k++) begin
            run_cycle();
            check_eq("lat3_fetch_wait", 32'(s_fw), (k % 3 != 0) ? 32'd1 : 32'd0);
            check_eq("lat3_valid", 32'(valid_ID), (k == 3 || k == 6) ? 32'd1 : 32'd0);
            if (!(k == 3 || k == 6)) check_eq("lat3_bubble", instr_ID, C_NOP);
        end
        check_eq("lat3_fw_count", 32'(fw_count), 32'd4);

        // Redirect to 0x100 while the 0x1C request is outstanding
        exp_addr_q.push_back(32'h100);
        exp_addr_q.push_back(32'h104);
        exp_pc_q.push_back(32'h100);
        BranchTaken = 1'b1;
        redirect_pc = 32'h100;
        flush_IFID  = 1'b1;
        run_cycle();
        check_eq("flush_valid", 32'(valid_ID), 32'd0);
        check_eq("flush_instr", instr_ID, C_NOP);
        check_eq("flush_pc_kept", pc_ID, 32'h18);
        BranchTaken = 1'b0;
        flush_IFID  = 1'b0;
        run_cycle();
        check_eq("discard_wait", 32'(s_fw), 32'd1);
        check_eq("discard_noreq", 32'(s_req), 32'd0);
        run_cycle();
        check_eq("discard_drop_noreq", 32'(s_req), 32'd0);
        check_eq("discard_drop_valid", 32'(valid_ID), 32'd0);
        run_cycle();
        check_eq("redirect_addr", s_addr, 32'h100);
        for (int i = 0; i < 3; i++) run_cycle();
        check_eq("redirect_pc_ID", pc_ID, 32'h100);

        // Redirect (unaligned target) coinciding with rvalid and stall
        exp_addr_q.push_back(32'h200);
        exp_addr_q.push_back(32'h204);
        exp_pc_q.push_back(32'h200);
        run_cycle();
        run_cycle();
        BranchTaken = 1'b1;
        redirect_pc = 32'h203;
        stall       = 1'b1;
        run_cycle();
        check_eq("bt_rvalid_noreq", 32'(s_req), 32'd0);
        check_eq("bt_stall_pc_ID", pc_ID, 32'h100);
        BranchTaken = 1'b0;
        stall       = 1'b0;
        lat         = 1;
        run_cycle();
        check_eq("bt_fetch_addr", s_addr, 32'h200);
        check_eq("bt_no_hold_valid", 32'(valid_ID), 32'd0);
        run_cycle();

        // Reset while HOLD carries a buffered instruction (0x204)
        stall = 1'b1;
        run_cycle();
        run_cycle();
        check_eq("hold2_noreq", 32'(s_req), 32'd0);
        rst = 1'b1;
        run_cycle();
        check_eq("rst_hold_req", 32'(s_req), 32'd0);
        check_eq("rst_hold_valid", 32'(valid_ID), 32'd0);
        check_eq("rst_hold_instr", instr_ID, C_NOP);
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        exp_pc_q.push_back(32'h0);
        rst   = 1'b0;
        stall = 1'b0;
        run_cycle();
        check_eq("post_rst_req", 32'(s_req), 32'd1);
        check_eq("post_rst_addr", s_addr, 32'h0);
        check_eq("post_rst_valid", 32'(valid_ID), 32'd0);
        run_cycle();
        check_eq("post_rst_pc_ID", pc_ID, 32'h0);

        check_eq("addr_left", 32'(exp_addr_q.size()), 32'd0);
        check_eq("id_left", 32'(exp_pc_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
